// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared encodings for the MIPS memory stage. The memory-op
//               codes are the same ones produced by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Memory operation encodings (2'b11 is reserved and behaves like NONE)
    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load data alignment. Selects the addressed
//               byte lane (little-endian) and sign- or zero-extends it; word
//               loads pass the read data through unchanged.
// Ports       : rdata_i  read data from memory
//               lane_i   byte lane (address bits [1:0])
//               byte_i   1 = byte load
//               sign_i   1 = sign-extend the byte
//               data_o   aligned writeback data
// Revision    : 1.0 - initial release
// ============================================================================
module load_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0] w_byte;

    assign w_byte = rdata_i[8*lane_i +: 8];

    always_comb begin
        data_o = rdata_i;
        if (byte_i) begin
            data_o = sign_i ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory stage of the 5-stage MIPS pipeline. Registers the EX
//               result, performs loads/stores over a req/ack data-memory
//               port, back-pressures EX while an access is outstanding and
//               retires one writeback per instruction.
// Config      : MEM_STAGE_BYTE_EN - enables byte loads/stores (lane select,
//               sign/zero extension, one-hot byte enables). Undefined: word
//               accesses only.
// Parameters  : TIMEOUT - ACCESS cycles without ack before abort (0 = never)
// Ports       : clk, rst                 clock, synchronous active-high reset
//               ex_*                     instruction from EX (valid/ready)
//               dmem_*                   data-memory request/ack port
//               wb_*                     writeback to WB (one-cycle valid)
// Revision    : 1.0 - initial release
// ============================================================================
import mem_stage_pkg::*;

module mem_stage #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [1:0]  ex_memop,
    input  logic        ex_byte,
    input  logic        ex_sign,
    input  logic [4:0]  ex_rw,
    input  logic        ex_regwr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rw,
    output logic        wb_regwr,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] res_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        load_q;
    logic [4:0]  rw_q;
    logic        regwr_q;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rw_q, wb_rw_d;
    logic        wb_regwr_q, wb_regwr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_err_q, wb_err_d;

    logic        w_accept;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_load_data;

    assign ex_ready = (state_q == ST_IDLE) && !rst;
    assign w_accept = ex_valid && ex_ready;

`ifdef MEM_STAGE_BYTE_EN
    logic [1:0] lane_q;
    logic       byte_q;
    logic       sign_q;

    // Byte stores replicate the byte on every lane; the enable picks the lane.
    assign w_be    = ex_byte ? (4'b0001 << ex_result[1:0]) : 4'hF;
    assign w_wdata = ex_byte ? {4{ex_store_data[7:0]}} : ex_store_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'b00;
            byte_q <= 1'b0;
            sign_q <= 1'b0;
        end else if (w_accept) begin
            lane_q <= ex_result[1:0];
            byte_q <= ex_byte;
            sign_q <= ex_sign;
        end
    end

    load_align u_load_align (
        .rdata_i (dmem_rdata),
        .lane_i  (lane_q),
        .byte_i  (byte_q),
        .sign_i  (sign_q),
        .data_o  (w_load_data)
    );
`else
    logic w_unused_byte_ctl;

    assign w_unused_byte_ctl = ex_byte ^ ex_sign;
    assign w_be        = 4'hF;
    assign w_wdata     = ex_store_data;
    assign w_load_data = dmem_rdata;
`endif

    // Next-state and writeback selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_regwr_d = 1'b0;
        wb_err_d   = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_mem_op(ex_memop)) begin
                        state_d = ST_ACCESS;
                        cnt_d   = 32'd0;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = ex_rw;
                        wb_regwr_d = ex_regwr;
                        wb_data_d  = ex_result;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    // An ack in the timeout cycle still completes normally.
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = rw_q;
                    wb_regwr_d = load_q && regwr_q;
                    wb_data_d  = load_q ? w_load_data : res_q;
                end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
                    // cnt_q counts completed ack-less cycles; this is the
                    // TIMEOUT-th one, so the access is abandoned.
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    wb_rw_d    = rw_q;
                    wb_data_d  = res_q;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 32'd0;
            res_q      <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'h0;
            we_q       <= 1'b0;
            load_q     <= 1'b0;
            rw_q       <= 5'd0;
            regwr_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 5'd0;
            wb_regwr_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_regwr_q <= wb_regwr_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
            // Captures only happen in IDLE, so request fields stay stable
            // for the whole access.
            if (w_accept) begin
                res_q   <= ex_result;
                wdata_q <= w_wdata;
                be_q    <= w_be;
                we_q    <= (ex_memop == MEMOP_STORE);
                load_q  <= (ex_memop == MEMOP_LOAD);
                rw_q    <= ex_rw;
                regwr_q <= ex_regwr;
            end
        end
    end

    assign dmem_req   = (state_q == ST_ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = {res_q[31:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign wb_valid = wb_valid_q;
    assign wb_rw    = wb_rw_q;
    assign wb_regwr = wb_regwr_q;
    assign wb_data  = wb_data_q;
    assign wb_err   = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage. A driver issues directed and
//               random instructions and pushes the expected writeback; a
//               memory responder acks after a chosen delay and checks the
//               request; a monitor pops and compares each writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [1:0]  ex_memop;
    logic        ex_byte;
    logic        ex_sign;
    logic [4:0]  ex_rw;
    logic        ex_regwr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rw;
    logic        wb_regwr;
    logic [31:0] wb_data;
    logic        wb_err;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_memop      (ex_memop),
        .ex_byte       (ex_byte),
        .ex_sign       (ex_sign),
        .ex_rw         (ex_rw),
        .ex_regwr      (ex_regwr),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rw         (wb_rw),
        .wb_regwr      (wb_regwr),
        .wb_data       (wb_data),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rw;
        logic        regwr;
        logic        err;
        logic        chk_data;
    } exp_t;

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_t;

    exp_t sb[$];
    mem_t mq[$];
    int   errors = 0;
    int   checks = 0;
    bit   manual = 1'b0;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [31:0] rdata,
                                           input logic byt, input logic sgn);
        logic [31:0] b;
        b = rdata;
`ifdef MEM_STAGE_BYTE_EN
        if (byt) begin
            b = (rdata >> (8 * addr[1:0])) & 32'hFF;
            if (sgn && b >= 32'd128) b = b + 32'hFFFFFF00;
        end
`else
        if (byt && sgn && addr[0]) b = rdata;
`endif
        return b;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input logic byt);
`ifdef MEM_STAGE_BYTE_EN
        if (byt) return 4'(1 << addr[1:0]);
`else
        if (byt && addr[0]) return 4'hF;
`endif
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic byt);
`ifdef MEM_STAGE_BYTE_EN
        if (byt) return (sd & 32'hFF) * 32'h01010101;
`else
        if (byt) return sd;
`endif
        return sd;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] res, input logic [31:0] sd, input logic [1:0] op,
                         input logic byt, input logic sgn, input logic [4:0] rw, input logic rwe,
                         input int d, input logic [31:0] rdata, input bit track);
        int   n;
        exp_t e;
        mem_t m;
        bit   is_mem, tmo;
        ex_result = res; ex_store_data = sd; ex_memop = op; ex_byte = byt;
        ex_sign = sgn; ex_rw = rw; ex_regwr = rwe; ex_valid = 1'b1;
        n = 0;
        while (!ex_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) begin
            check(1'b0, "ex_ready_wait", {31'd0, ex_ready}, 32'd1);
            ex_valid = 1'b0;
            return;
        end
        if (track) begin
            is_mem     = (op == 2'b01) || (op == 2'b10);
            tmo        = is_mem && (d > TO);
            e.rw       = rw;
            e.err      = tmo;
            e.regwr    = (tmo || op == 2'b10) ? 1'b0 : rwe;
            e.chk_data = !tmo;
            e.data     = (op == 2'b01) ? m_load(res, rdata, byt, sgn) : res;
            sb.push_back(e);
            if (is_mem) begin
                m.d = d; m.addr = res & 32'hFFFFFFFC; m.we = (op == 2'b10);
                m.be = m_be(res, byt); m.wdata = m_wdata(sd, byt); m.rdata = rdata;
                mq.push_back(m);
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || mq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(sb.size() == 0 && mq.size() == 0, "drain", 32'(sb.size()), 32'd0);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int   req_cnt;
        bit   post_chk;
        mem_t m;
        req_cnt  = 0;
        post_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (!manual) begin
                if (post_chk) begin
                    post_chk = 1'b0;
                    check(wb_valid && !dmem_req && ex_ready, "after_ack",
                          {29'd0, wb_valid, dmem_req, ex_ready}, 32'h5);
                end
                dmem_ack = 1'b0;
                if (dmem_req) begin
                    req_cnt++;
                    check(!ex_ready, "ready_during_req", {31'd0, ex_ready}, 32'd0);
                    if (mq.size() == 0) begin
                        check(1'b0, "unexpected_req", dmem_addr, 32'd0);
                    end else begin
                        m = mq[0];
                        check(dmem_addr == m.addr, "dmem_addr", dmem_addr, m.addr);
                        check(dmem_we == m.we, "dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
                        if (m.we) begin
                            check(dmem_be == m.be, "dmem_be", {28'd0, dmem_be}, {28'd0, m.be});
                            check(dmem_wdata == m.wdata, "dmem_wdata", dmem_wdata, m.wdata);
                        end
                        if (req_cnt == m.d) begin
                            dmem_ack   = 1'b1;
                            dmem_rdata = m.rdata;
                            void'(mq.pop_front());
                            req_cnt  = 0;
                            post_chk = 1'b1;
                        end else if (req_cnt == TO) begin
                            void'(mq.pop_front());
                            req_cnt  = 0;
                            post_chk = 1'b1;
                        end
                    end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    // ---------------- writeback monitor ----------------
    initial begin
        exp_t        e;
        bit          seen;
        logic [31:0] last_data;
        logic [4:0]  last_rw;
        seen = 1'b0;
        last_data = '0;
        last_rw = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (wb_valid) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_wb", wb_data, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check(wb_rw == e.rw, "wb_rw", {27'd0, wb_rw}, {27'd0, e.rw});
                    check(wb_regwr == e.regwr, "wb_regwr", {31'd0, wb_regwr}, {31'd0, e.regwr});
                    check(wb_err == e.err, "wb_err", {31'd0, wb_err}, {31'd0, e.err});
                    if (e.chk_data) check(wb_data == e.data, "wb_data", wb_data, e.data);
                end
                seen = 1'b1;
                last_data = wb_data;
                last_rw = wb_rw;
            end else begin
                check(!wb_regwr && !wb_err, "idle_wb_flags", {30'd0, wb_regwr, wb_err}, 32'd0);
                if (seen) check(wb_data == last_data && wb_rw == last_rw, "wb_hold", wb_data, last_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_memop = '0;
        ex_byte = 1'b0; ex_sign = 1'b0; ex_rw = '0; ex_regwr = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check(!ex_ready, "rst_ex_ready", {31'd0, ex_ready}, 32'd0);
        check(!dmem_req, "rst_req", {31'd0, dmem_req}, 32'd0);
        check(!wb_valid && wb_data == 32'd0 && wb_rw == 5'd0, "rst_wb", wb_data, 32'd0);
        check(dmem_be == 4'h0 && dmem_addr == 32'd0, "rst_dmem", dmem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ALU op, latency 1
        issue(32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b1, 0, 32'h0, 1'b1);
        check(wb_valid, "alu_latency", {31'd0, wb_valid}, 32'd1);
        // Word load with ack in the third request cycle
        issue(32'h104, 32'h0, 2'b01, 1'b0, 1'b0, 5'd5, 1'b1, 3, 32'hDEADBEEF, 1'b1);
        drain();
        // Store acked in its first request cycle
        issue(32'h20, 32'h55AA, 2'b10, 1'b0, 1'b0, 5'd7, 1'b1, 1, 32'h0, 1'b1);
        drain();
        // Byte loads from lane 3, signed and unsigned
        issue(32'h103, 32'h0, 2'b01, 1'b1, 1'b1, 5'd9, 1'b1, 2, 32'h80112233, 1'b1);
        issue(32'h103, 32'h0, 2'b01, 1'b1, 1'b0, 5'd10, 1'b1, 1, 32'h80112233, 1'b1);
        drain();

        // Random mix, including reserved memop and delays past the timeout
        for (int i = 0; i < 60; i++) begin
            issue($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(1, 6)), $urandom, 1'b1);
        end
        drain();

        // Timeout: ack never arrives, then a normal load
        issue(32'h300, 32'h0, 2'b01, 1'b0, 1'b0, 5'd12, 1'b1, 99, 32'h0, 1'b1);
        issue(32'h304, 32'h0, 2'b01, 1'b0, 1'b0, 5'd13, 1'b1, 2, 32'h12345678, 1'b1);
        drain();

        // Reset mid-access with a late ack
        manual = 1'b1;
        issue(32'h200, 32'h0, 2'b01, 1'b0, 1'b0, 5'd4, 1'b1, 0, 32'h0, 1'b0);
        check(dmem_req, "mid_access_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(!dmem_req && !ex_ready, "rst_abandon", {30'd0, dmem_req, ex_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(ex_ready, "ready_after_rst", {31'd0, ex_ready}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        check(!wb_valid && !dmem_req, "late_ack_ignored", {30'd0, wb_valid, dmem_req}, 32'd0);
        manual = 1'b0;
        issue(32'h208, 32'h0, 2'b01, 1'b0, 1'b0, 5'd6, 1'b1, 1, 32'h0BADF00D, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
